// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between EX, the muldiv sequencer and the shared
// iterative multiplier/divider. slave = the sequencer, master = everything around it.
interface muldiv_sequencer_if #(
  parameter int XLEN = 64,
  parameter int OP_W = 3
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] op;
  logic            word_op;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;
  logic            mul_valid;
  logic            mul_ready;
  logic [1:0]      mul_sign;
  logic            mul_out_valid;
  logic [XLEN-1:0] mul_hi;
  logic [XLEN-1:0] mul_lo;
  logic            div_valid;
  logic            div_ready;
  logic            div_signed;
  logic            div_out_valid;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;
  logic [XLEN-1:0] a_out;
  logic [XLEN-1:0] b_out;
  logic            kill;

  modport slave (
    input  flush, in_valid, op, word_op, src1, src2, out_ready,
           mul_ready, mul_out_valid, mul_hi, mul_lo,
           div_ready, div_out_valid, quotient, remainder,
    output in_ready, out_valid, result, busy, mul_valid, mul_sign,
           div_valid, div_signed, a_out, b_out, kill
  );

  modport master (
    output flush, in_valid, op, word_op, src1, src2, out_ready,
           mul_ready, mul_out_valid, mul_hi, mul_lo,
           div_ready, div_out_valid, quotient, remainder,
    input  in_ready, out_valid, result, busy, mul_valid, mul_sign,
           div_valid, div_signed, a_out, b_out, kill
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Sequences one M-extension op at a time through the shared multiplier/divider,
// resolving divide-by-zero and signed overflow locally without engaging the divider.
module muldiv_sequencer #(
  parameter int XLEN = 64,
  parameter int OP_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  muldiv_sequencer_if.slave bus
);

  localparam logic [OP_W-1:0] OP_MUL    = 3'd0;
  localparam logic [OP_W-1:0] OP_MULH   = 3'd1;
  localparam logic [OP_W-1:0] OP_MULHSU = 3'd2;
  localparam logic [OP_W-1:0] OP_MULHU  = 3'd3;
  localparam logic [OP_W-1:0] OP_DIV    = 3'd4;
  localparam logic [OP_W-1:0] OP_DIVU   = 3'd5;
  localparam logic [OP_W-1:0] OP_REM    = 3'd6;
  localparam logic [OP_W-1:0] OP_REMU   = 3'd7;

  localparam logic [XLEN-1:0] ZERO       = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ALL_ONES   = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MOST_NEG_D = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MOST_NEG_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    return {{(XLEN-32){1'b0}}, v};
  endfunction

  // W-variant results are always the sign-extended low word, signed or not
  function automatic logic [XLEN-1:0] word_fix(input logic word, input logic [XLEN-1:0] v);
    if (word) begin
      return sext32(v[31:0]);
    end else begin
      return v;
    end
  endfunction

  state_t          state_r;
  logic [OP_W-1:0] op_r;
  logic            word_r;
  logic [XLEN-1:0] a_r;
  logic [XLEN-1:0] b_r;
  logic [XLEN-1:0] result_r;
  logic            out_valid_r;
  logic            busy_r;
  logic            mul_valid_r;
  logic            div_valid_r;
  logic            div_signed_r;
  logic [1:0]      mul_sign_r;
  logic            kill_r;

  logic [OP_W-1:0] eff_op_s;
  logic            is_div_s;
  logic            div_signed_s;
  logic [XLEN-1:0] a_ext_s;
  logic [XLEN-1:0] b_ext_s;
  logic [XLEN-1:0] most_neg_s;
  logic [1:0]      mul_sign_s;
  logic            special_s;
  logic [XLEN-1:0] special_res_s;
  logic [XLEN-1:0] raw_s;
  logic            accept_s;
  logic            unit_ready_s;
  logic            unit_done_s;

  assign bus.in_ready = !rst && (state_r == S_IDLE) && !bus.flush;
  assign accept_s     = bus.in_valid && bus.in_ready;
  assign unit_ready_s = op_r[2] ? bus.div_ready : bus.mul_ready;
  assign unit_done_s  = op_r[2] ? bus.div_out_valid : bus.mul_out_valid;

  // Decode the incoming op: effective op, operand extension, sign fields, special cases
  always_comb begin
    is_div_s     = bus.op[2];
    div_signed_s = bus.op[2] && !bus.op[0];
    if (bus.word_op && !bus.op[2]) begin
      eff_op_s = OP_MUL;
    end else begin
      eff_op_s = bus.op;
    end
    if (bus.word_op) begin
      most_neg_s = MOST_NEG_W;
      if (is_div_s && bus.op[0]) begin
        a_ext_s = zext32(bus.src1[31:0]);
        b_ext_s = zext32(bus.src2[31:0]);
      end else begin
        a_ext_s = sext32(bus.src1[31:0]);
        b_ext_s = sext32(bus.src2[31:0]);
      end
    end else begin
      most_neg_s = MOST_NEG_D;
      a_ext_s    = bus.src1;
      b_ext_s    = bus.src2;
    end
    case (eff_op_s)
      OP_MULH:   mul_sign_s = 2'b11;
      OP_MULHSU: mul_sign_s = 2'b10;
      default:   mul_sign_s = 2'b00;
    endcase
    // op[1] separates REM/REMU from DIV/DIVU
    if (is_div_s && (b_ext_s == ZERO)) begin
      special_s     = 1'b1;
      special_res_s = bus.op[1] ? a_ext_s : ALL_ONES;
    end else if (div_signed_s && (a_ext_s == most_neg_s) && (b_ext_s == ALL_ONES)) begin
      special_s     = 1'b1;
      special_res_s = bus.op[1] ? ZERO : a_ext_s;
    end else begin
      special_s     = 1'b0;
      special_res_s = ZERO;
    end
  end

  // Select the unit output that carries the answer for the latched op
  always_comb begin
    case (op_r)
      OP_MUL:                        raw_s = bus.mul_lo;
      OP_MULH, OP_MULHSU, OP_MULHU:  raw_s = bus.mul_hi;
      OP_DIV, OP_DIVU:               raw_s = bus.quotient;
      OP_REM, OP_REMU:               raw_s = bus.remainder;
      default:                       raw_s = ZERO;
    endcase
  end

  // Sequencer FSM with all of its outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      op_r         <= OP_MUL;
      word_r       <= 1'b0;
      a_r          <= ZERO;
      b_r          <= ZERO;
      result_r     <= ZERO;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      mul_valid_r  <= 1'b0;
      div_valid_r  <= 1'b0;
      div_signed_r <= 1'b0;
      mul_sign_r   <= 2'b00;
      kill_r       <= 1'b0;
    end else if (bus.flush) begin
      state_r     <= S_IDLE;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      mul_valid_r <= 1'b0;
      div_valid_r <= 1'b0;
      kill_r      <= (state_r == S_ISSUE) || (state_r == S_WAIT);
    end else begin
      kill_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            op_r         <= eff_op_s;
            word_r       <= bus.word_op;
            a_r          <= a_ext_s;
            b_r          <= b_ext_s;
            mul_sign_r   <= mul_sign_s;
            div_signed_r <= div_signed_s;
            busy_r       <= 1'b1;
            if (special_s) begin
              result_r    <= word_fix(bus.word_op, special_res_s);
              out_valid_r <= 1'b1;
              state_r     <= S_DONE;
            end else begin
              mul_valid_r <= !eff_op_s[2];
              div_valid_r <= eff_op_s[2];
              state_r     <= S_ISSUE;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (unit_ready_s) begin
            mul_valid_r <= 1'b0;
            div_valid_r <= 1'b0;
            state_r     <= S_WAIT;
          end else begin
            state_r <= S_ISSUE;
          end
        end
        S_WAIT: begin
          if (unit_done_s) begin
            result_r    <= word_fix(word_r, raw_s);
            out_valid_r <= 1'b1;
            state_r     <= S_DONE;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= S_IDLE;
          end else begin
            state_r <= S_DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          mul_valid_r <= 1'b0;
          div_valid_r <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.out_valid  = out_valid_r;
  assign bus.result     = result_r;
  assign bus.busy       = busy_r;
  assign bus.mul_valid  = mul_valid_r;
  assign bus.mul_sign   = mul_sign_r;
  assign bus.div_valid  = div_valid_r;
  assign bus.div_signed = div_signed_r;
  assign bus.a_out      = a_r;
  assign bus.b_out      = b_r;
  assign bus.kill       = kill_r;

endmodule
